tcam_lookup_sched: RTL and testbench

TCAM_LOOKUP_SCHED -- requirements
Module: tcam_lookup_sched

---
 rtl/tcam_lookup_sched_if.sv | 45 ++++
 rtl/tcam_lookup_sched.sv | 176 +++++++++++++++++
 tb/tb_tcam_lookup_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_lookup_sched_if.sv
// Client-side bus of the TCAM lookup scheduler.
//   lk_valid/lk_id/lk_ready     : per-requester lookup request and one-hot grant
//   rsp_valid/rsp_port/rsp_hit/
//   rsp_dst/rsp_ready           : lookup result handshake
//   wr_valid/wr_addr/wr_data/
//   wr_mask/wr_ready            : TCAM entry write
//   flush_req/flush_done        : invalidate-all request and completion pulse
// master = requesters side, slave = scheduler side.
interface tcam_lookup_sched_if #(
  parameter int NUM_REQ     = 4,
  parameter int ID_Width    = 4,
  parameter int AddressSize = 4
);
  localparam int Bits = 2 * ID_Width;
  localparam int PW   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          lk_valid;
  logic [NUM_REQ*ID_Width-1:0] lk_id;
  logic [NUM_REQ-1:0]          lk_ready;

  logic                        rsp_valid;
  logic [PW-1:0]               rsp_port;
  logic                        rsp_hit;
  logic [ID_Width-1:0]         rsp_dst;
  logic                        rsp_ready;

  logic                        wr_valid;
  logic [AddressSize-1:0]      wr_addr;
  logic [Bits-1:0]             wr_data;
  logic [Bits-1:0]             wr_mask;
  logic                        wr_ready;

  logic                        flush_req;
  logic                        flush_done;

  modport master (
    output lk_valid, lk_id, rsp_ready, wr_valid, wr_addr, wr_data, wr_mask, flush_req,
    input  lk_ready, rsp_valid, rsp_port, rsp_hit, rsp_dst, wr_ready, flush_done
  );

  modport slave (
    input  lk_valid, lk_id, rsp_ready, wr_valid, wr_addr, wr_data, wr_mask, flush_req,
    output lk_ready, rsp_valid, rsp_port, rsp_hit, rsp_dst, wr_ready, flush_done
  );
endinterface

// File: rtl/tcam_lookup_sched.sv
// TCAM lookup scheduler: arbitrates flush, entry writes and round-robin lookups
// onto a single TCAM macro, one operation in flight at a time.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   bus (slave)       : lookup / response / write / flush handshakes
//   tcam_cs .. tcam_a : macro control strobes, data, mask and address
//   tcam_do, tcam_hit,
//   tcam_hitline      : macro read data, compare hit and per-word hit lines
//
// state   | meaning
// IDLE    | arbitrate flush > write > lookup
// WRITE   | write captured entry into TCAM (valid bit set)
// FLUSH   | invalidate all entries, pulse flush_done
// COMPARE | search with the granted packet ID in the upper half of the key
// READ    | read the first matching word, capture the result
// RESP    | hold the result until rsp_ready
module tcam_lookup_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ID_Width    = 4,
  parameter int Bits        = 2 * ID_Width,
  parameter int AddressSize = 4,
  parameter int Words       = 2 ** AddressSize,
  parameter int PW          = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  tcam_lookup_sched_if.slave     bus,
  output logic                   tcam_cs,
  output logic                   tcam_wr,
  output logic                   tcam_cmp,
  output logic                   tcam_rd,
  output logic                   tcam_flush,
  output logic                   tcam_vbi,
  output logic [Bits-1:0]        tcam_di,
  output logic [Bits-1:0]        tcam_mskb,
  output logic [AddressSize-1:0] tcam_a,
  input  logic [Bits-1:0]        tcam_do,
  input  logic                   tcam_hit,
  input  logic [Words-1:0]       tcam_hitline
);

  typedef enum logic [2:0] {IDLE, WRITE, FLUSH, COMPARE, READ, RESP} state_t;

  state_t                 state;
  logic [PW-1:0]          last_grant;
  logic [PW-1:0]          gnt_q;
  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          cand;
  logic                   gnt_any;
  logic [AddressSize-1:0] wr_addr_q;
  logic [AddressSize-1:0] hit_idx;
  logic                   idle_ok;
  logic                   wr_take;
  logic                   lk_take;
  logic                   unused_do;

  assign unused_do = ^tcam_do[Bits-1:ID_Width];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = last_grant + PW'(i + 1);
      if (!gnt_any && bus.lk_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Lowest matching word wins; no match reads word 0.
  always_comb begin
    hit_idx = '0;
    for (int i = Words - 1; i >= 0; i--) begin
      if (tcam_hitline[i]) hit_idx = AddressSize'(i);
    end
  end

  // Ready outputs are combinational so a request is accepted in the same
  // IDLE cycle it is granted; they stay low while reset is applied.
  assign idle_ok      = !rst && (state == IDLE);
  assign wr_take      = idle_ok && !bus.flush_req && bus.wr_valid;
  assign lk_take      = idle_ok && !bus.flush_req && !bus.wr_valid && gnt_any;
  assign bus.wr_ready = wr_take;

  always_comb begin
    bus.lk_ready = '0;
    if (lk_take) bus.lk_ready[gnt_idx] = 1'b1;
  end

  assign tcam_a = (state == WRITE) ? wr_addr_q :
                  (state == READ)  ? hit_idx   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= PW'(NUM_REQ - 1);
      gnt_q          <= '0;
      wr_addr_q      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_port   <= '0;
      bus.rsp_hit    <= 1'b0;
      bus.rsp_dst    <= '0;
      bus.flush_done <= 1'b0;
      tcam_cs        <= 1'b0;
      tcam_wr        <= 1'b0;
      tcam_cmp       <= 1'b0;
      tcam_rd        <= 1'b0;
      tcam_flush     <= 1'b0;
      tcam_vbi       <= 1'b0;
      tcam_di        <= '0;
      tcam_mskb      <= '0;
    end else begin
      // Strobes are single-cycle: set on entry to their state, cleared here.
      tcam_cs        <= 1'b0;
      tcam_wr        <= 1'b0;
      tcam_cmp       <= 1'b0;
      tcam_rd        <= 1'b0;
      tcam_flush     <= 1'b0;
      tcam_vbi       <= 1'b0;
      tcam_di        <= '0;
      tcam_mskb      <= '0;
      bus.flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state          <= FLUSH;
            tcam_cs        <= 1'b1;
            tcam_flush     <= 1'b1;
            bus.flush_done <= 1'b1;
          end else if (bus.wr_valid) begin
            state     <= WRITE;
            wr_addr_q <= bus.wr_addr;
            tcam_cs   <= 1'b1;
            tcam_wr   <= 1'b1;
            tcam_vbi  <= 1'b1;
            tcam_di   <= bus.wr_data;
            tcam_mskb <= bus.wr_mask;
          end else if (gnt_any) begin
            state      <= COMPARE;
            last_grant <= gnt_idx;
            gnt_q      <= gnt_idx;
            tcam_cs    <= 1'b1;
            tcam_cmp   <= 1'b1;
            // Key = {id, don't-care}; only the ID half takes part in the match.
            tcam_di    <= {bus.lk_id[gnt_idx*ID_Width +: ID_Width], {ID_Width{1'b0}}};
            tcam_mskb  <= {{ID_Width{1'b1}}, {ID_Width{1'b0}}};
          end
        end
        WRITE, FLUSH: state <= IDLE;
        COMPARE: begin
          state   <= READ;
          tcam_cs <= 1'b1;
          tcam_rd <= 1'b1;
        end
        READ: begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_port  <= gnt_q;
          bus.rsp_hit   <= tcam_hit;
          bus.rsp_dst   <= tcam_hit ? tcam_do[ID_Width-1:0] : '0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_lookup_sched.sv
module tb_tcam_lookup_sched;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 4;
  localparam int AW      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi;
  logic [7:0]  tcam_di, tcam_mskb, tcam_do;
  logic [3:0]  tcam_a;
  logic        tcam_hit;
  logic [15:0] tcam_hitline;

  always #5 clk = ~clk;

  tcam_lookup_sched_if #(.NUM_REQ(NUM_REQ), .ID_Width(IDW), .AddressSize(AW)) bus ();

  tcam_lookup_sched dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .tcam_cs      (tcam_cs),
    .tcam_wr      (tcam_wr),
    .tcam_cmp     (tcam_cmp),
    .tcam_rd      (tcam_rd),
    .tcam_flush   (tcam_flush),
    .tcam_vbi     (tcam_vbi),
    .tcam_di      (tcam_di),
    .tcam_mskb    (tcam_mskb),
    .tcam_a       (tcam_a),
    .tcam_do      (tcam_do),
    .tcam_hit     (tcam_hit),
    .tcam_hitline (tcam_hitline)
  );

  typedef struct packed {
    logic        flush;
    logic        wv;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  wm;
    logic [3:0]  lv;
    logic [15:0] lid;
    logic        rr;
    logic        hit;
    logic [7:0]  tdo;
    logic [15:0] hl;
    logic [3:0]  e_lkr;
    logic        e_wrr;
    logic        e_fd;
    logic        e_rv;
    logic [1:0]  e_port;
    logic        e_hit;
    logic [3:0]  e_dst;
    logic [5:0]  e_strb;   // {cs, wr, cmp, rd, flush, vbi}
    logic [3:0]  e_a;
    logic [7:0]  e_di;
    logic [7:0]  e_mskb;
  } vec_t;

  vec_t tbl [0:15];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] strb();
    return {tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi};
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.flush_req = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_mask   = '0;
    bus.lk_valid  = '0;
    bus.lk_id     = '0;
    bus.rsp_ready = 1'b0;
    tcam_hit      = 1'b0;
    tcam_do       = '0;
    tcam_hitline  = '0;
  endtask

  // Requests are held high during reset: ready outputs must still stay low.
  task automatic do_reset(input string tag);
    rst           = 1'b1;
    bus.flush_req = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.lk_valid  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " rst lk_ready"},   bus.lk_ready,   0);
    chk({tag, " rst wr_ready"},   bus.wr_ready,   0);
    chk({tag, " rst flush_done"}, bus.flush_done, 0);
    chk({tag, " rst rsp_valid"},  bus.rsp_valid,  0);
    chk({tag, " rst strobes"},    strb(),         0);
    chk({tag, " rst tcam_a"},     tcam_a,         0);
    chk({tag, " rst tcam_di"},    tcam_di,        0);
    chk({tag, " rst tcam_mskb"},  tcam_mskb,      0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gp[$], gc[$], rp[$], rc[$];
    int cyc;
    bit found, seen_rd;

    //            fl wv wa    wd     wm     lv    lid       rr hit tdo    hl         | lkr  wrr fd rv port hit dst   strb       a     di     mskb
    tbl[0]  = '{1'b0,1'b1,4'd3,8'h52,8'hFF,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b1,1'b0,1'b0,2'd0,1'b0,4'h0,6'b000000,4'd0,8'h00,8'h00};
    tbl[1]  = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b110001,4'd3,8'h52,8'hFF};
    tbl[2]  = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h1,16'h0005,1'b1,1'b1,8'h52,16'h0008, 4'h1,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b000000,4'd0,8'h00,8'h00};
    tbl[3]  = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b101000,4'd0,8'h50,8'hF0};
    tbl[4]  = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b100100,4'd3,8'h00,8'h00};
    tbl[5]  = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b1,2'd0,1'b1,4'h2,6'b000000,4'd0,8'h00,8'h00};
    tbl[6]  = '{1'b1,1'b1,4'd7,8'hAA,8'h0F,4'h4,16'h0900,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b000000,4'd0,8'h00,8'h00};
    tbl[7]  = '{1'b0,1'b1,4'd7,8'hAA,8'h0F,4'h4,16'h0900,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b1,1'b0,2'd0,1'b0,4'h0,6'b100010,4'd0,8'h00,8'h00};
    tbl[8]  = '{1'b0,1'b1,4'd7,8'hAA,8'h0F,4'h4,16'h0900,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b1,1'b0,1'b0,2'd0,1'b0,4'h0,6'b000000,4'd0,8'h00,8'h00};
    tbl[9]  = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h4,16'h0900,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b110001,4'd7,8'hAA,8'h0F};
    tbl[10] = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h4,16'h0900,1'b1,1'b1,8'h52,16'h0008, 4'h4,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b000000,4'd0,8'h00,8'h00};
    tbl[11] = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b101000,4'd0,8'h90,8'hF0};
    tbl[12] = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h5C,16'h0050, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b100100,4'd4,8'h00,8'h00};
    tbl[13] = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b0,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b1,2'd2,1'b1,4'hC,6'b000000,4'd0,8'h00,8'h00};
    tbl[14] = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b1,2'd2,1'b1,4'hC,6'b000000,4'd0,8'h00,8'h00};
    tbl[15] = '{1'b0,1'b0,4'd0,8'h00,8'h00,4'h0,16'h0000,1'b1,1'b1,8'h52,16'h0008, 4'h0,1'b0,1'b0,1'b0,2'd0,1'b0,4'h0,6'b000000,4'd0,8'h00,8'h00};

    clear_inputs();
    do_reset("t0");

    // Write, lookup hit on port 0, then flush > write > lookup priority.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      bus.flush_req = tbl[i].flush;
      bus.wr_valid  = tbl[i].wv;
      bus.wr_addr   = tbl[i].wa;
      bus.wr_data   = tbl[i].wd;
      bus.wr_mask   = tbl[i].wm;
      bus.lk_valid  = tbl[i].lv;
      bus.lk_id     = tbl[i].lid;
      bus.rsp_ready = tbl[i].rr;
      tcam_hit      = tbl[i].hit;
      tcam_do       = tbl[i].tdo;
      tcam_hitline  = tbl[i].hl;
      @(negedge clk);
      chk($sformatf("row%0d lk_ready", i),   bus.lk_ready,   tbl[i].e_lkr);
      chk($sformatf("row%0d wr_ready", i),   bus.wr_ready,   tbl[i].e_wrr);
      chk($sformatf("row%0d flush_done", i), bus.flush_done, tbl[i].e_fd);
      chk($sformatf("row%0d rsp_valid", i),  bus.rsp_valid,  tbl[i].e_rv);
      chk($sformatf("row%0d strobes", i),    strb(),         tbl[i].e_strb);
      chk($sformatf("row%0d tcam_a", i),     tcam_a,         tbl[i].e_a);
      chk($sformatf("row%0d tcam_di", i),    tcam_di,        tbl[i].e_di);
      chk($sformatf("row%0d tcam_mskb", i),  tcam_mskb,      tbl[i].e_mskb);
      if (tbl[i].e_rv) begin
        chk($sformatf("row%0d rsp_port", i), bus.rsp_port, tbl[i].e_port);
        chk($sformatf("row%0d rsp_hit", i),  bus.rsp_hit,  tbl[i].e_hit);
        chk($sformatf("row%0d rsp_dst", i),  bus.rsp_dst,  tbl[i].e_dst);
      end
    end

    // All four requesters held: grants 0,1,2,3,0 with responses 4 cycles apart.
    do_reset("s1");
    @(posedge clk);
    #1;
    bus.lk_valid  = 4'hF;
    bus.lk_id     = 16'h4321;
    bus.rsp_ready = 1'b1;
    tcam_hit      = 1'b1;
    tcam_do       = 8'h11;
    tcam_hitline  = 16'h0001;
    cyc = 0;
    while (rp.size() < 5 && cyc < 60) begin
      @(negedge clk);
      if (bus.lk_ready != 0) begin
        chk("s1 grant onehot", $countones(bus.lk_ready), 1);
        gp.push_back(onehot_idx(bus.lk_ready));
        gc.push_back(cyc);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rp.push_back(int'(bus.rsp_port));
        rc.push_back(cyc);
      end
      cyc++;
    end
    chk("s1 rsp count", rp.size(), 5);
    if (rp.size() == 5 && gp.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("s1 grant%0d port", i), gp[i], i % 4);
        chk($sformatf("s1 rsp%0d port", i), rp[i], i % 4);
        chk($sformatf("s1 rsp%0d latency", i), rc[i] - gc[i], 3);
      end
      for (int i = 0; i < 4; i++) chk($sformatf("s1 rsp%0d spacing", i), rc[i+1] - rc[i], 4);
    end

    // Miss with rsp_ready held low: result held, no new grant meanwhile.
    do_reset("s2");
    @(posedge clk);
    #1;
    bus.lk_valid  = 4'b0010;
    bus.lk_id     = 16'h0030;
    tcam_hit      = 1'b0;
    tcam_hitline  = 16'h0000;
    tcam_do       = 8'hFF;
    found   = 0;
    seen_rd = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (tcam_rd) begin
        seen_rd = 1;
        chk("s2 miss read addr", tcam_a, 0);
      end
      if (bus.rsp_valid) found = 1;
    end
    chk("s2 rsp seen", found, 1);
    chk("s2 read seen", seen_rd, 1);
    if (found) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("s2 hold%0d rsp_valid", k), bus.rsp_valid, 1);
        chk($sformatf("s2 hold%0d rsp_hit", k),   bus.rsp_hit,   0);
        chk($sformatf("s2 hold%0d rsp_dst", k),   bus.rsp_dst,   0);
        chk($sformatf("s2 hold%0d rsp_port", k),  bus.rsp_port,  1);
        chk($sformatf("s2 hold%0d lk_ready", k),  bus.lk_ready,  0);
        @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      chk("s2 accept rsp_valid", bus.rsp_valid, 1);
      @(negedge clk);
      chk("s2 after rsp_valid", bus.rsp_valid, 0);
      chk("s2 after regrant", bus.lk_ready, 4'b0010);
    end

    // Reset during READ abandons the lookup and restarts arbitration at port 0.
    do_reset("s3");
    @(posedge clk);
    #1;
    bus.lk_valid  = 4'b0100;
    bus.lk_id     = 16'h0500;
    bus.rsp_ready = 1'b1;
    tcam_hit      = 1'b1;
    tcam_hitline  = 16'h0008;
    tcam_do       = 8'h52;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (tcam_rd) found = 1;
    end
    chk("s3 read seen", found, 1);
    rst          = 1'b1;
    bus.lk_valid = 4'b1001;
    bus.lk_id    = 16'h0000;
    @(negedge clk);
    chk("s3 rst rsp_valid", bus.rsp_valid, 0);
    chk("s3 rst tcam_rd",   tcam_rd,       0);
    chk("s3 rst tcam_cs",   tcam_cs,       0);
    chk("s3 rst lk_ready",  bus.lk_ready,  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s3 grant port0", bus.lk_ready, 4'b0001);
    @(posedge clk);
    #1;
    bus.lk_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("s3 rsp_valid", bus.rsp_valid, 1);
    chk("s3 rsp_port",  bus.rsp_port,  0);

    @(posedge clk);
    #1;
    clear_inputs();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
